// File: rtl/psram_req_arbiter.sv
// rtl/psram_req_arbiter.sv - round-robin arbiter sharing one QSPI PSRAM controller port between two clients
// Optional WAIT watchdog with controller abort: define PSRAM_ARB_TIMEOUT_EN.
module psram_req_arbiter #(
   parameter int ADDR_W         = 24,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic              err0,
   output logic              err1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              mem_start,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_abort,
   input  logic              mem_done,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              grant_id
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t state, next_state;
   logic   last_grant;
   logic   grant_en;
   logic   grant_pick;

   if (TIMEOUT_CYCLES < 2) begin : g_param_check
      $error("psram_req_arbiter: TIMEOUT_CYCLES must be at least 2");
   end

`ifdef PSRAM_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] wait_cnt;
   logic             timeout_hit;
   logic             timed_out;

   assign mem_abort = timeout_hit;
   assign err0      = ack0 & timed_out;
   assign err1      = ack1 & timed_out;
`else
   assign mem_abort = 1'b0;
   assign err0      = 1'b0;
   assign err1      = 1'b0;
`endif

   assign busy = (state != IDLE);

   always_comb begin
      next_state = state;
      grant_en   = 1'b0;
      grant_pick = 1'b0;
      mem_start  = 1'b0;
      ack0       = 1'b0;
      ack1       = 1'b0;
`ifdef PSRAM_ARB_TIMEOUT_EN
      timeout_hit = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (req0 || req1) begin
               grant_en = 1'b1;
               // On a tie the client that was not served last wins.
               grant_pick = (req0 && req1) ? ~last_grant : req1;
               next_state = ISSUE;
            end
         end
         ISSUE: begin
            mem_start  = 1'b1;
            next_state = WAIT;
         end
         WAIT: begin
            if (mem_done) begin
               next_state = RESP;
            end
`ifdef PSRAM_ARB_TIMEOUT_EN
            else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               timeout_hit = 1'b1;
               next_state  = RESP;
            end
`endif
         end
         RESP: begin
            ack0       = ~grant_id;
            ack1       = grant_id;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         grant_id   <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         rdata0     <= '0;
         rdata1     <= '0;
`ifdef PSRAM_ARB_TIMEOUT_EN
         wait_cnt   <= '0;
         timed_out  <= 1'b0;
`endif
      end else begin
         state <= next_state;
         if (grant_en) begin
            grant_id  <= grant_pick;
            mem_we    <= grant_pick ? we1    : we0;
            mem_addr  <= grant_pick ? addr1  : addr0;
            mem_wdata <= grant_pick ? wdata1 : wdata0;
         end
         // Writes complete with an ack but leave the client's read data untouched.
         if (state == WAIT && mem_done && !mem_we) begin
            if (grant_id) rdata1 <= mem_rdata;
            else          rdata0 <= mem_rdata;
         end
         if (state == RESP) begin
            last_grant <= grant_id;
         end
`ifdef PSRAM_ARB_TIMEOUT_EN
         if (state == ISSUE)      wait_cnt <= '0;
         else if (state == WAIT)  wait_cnt <= wait_cnt + CNT_W'(1);
         if (grant_en)            timed_out <= 1'b0;
         if (timeout_hit) begin
            timed_out <= 1'b1;
            if (!mem_we) begin
               if (grant_id) rdata1 <= '0;
               else          rdata0 <= '0;
            end
         end
`endif
      end
   end

endmodule

// File: tb/tb_psram_req_arbiter.sv
// tb/tb_psram_req_arbiter.sv - scoreboard bench for psram_req_arbiter with a latency-programmable PSRAM controller model
module tb_psram_req_arbiter;

   localparam int ADDR_W = 24;
   localparam int DATA_W = 32;
   localparam int TMO    = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
   logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
   logic ack0, ack1, err0, err1;
   logic [DATA_W-1:0] rdata0, rdata1;
   logic mem_start, mem_we, mem_abort;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic mem_done;
   logic [DATA_W-1:0] mem_rdata;
   logic busy, grant_id;

   logic ctrl_done = 1'b0, stray_done = 1'b0, ctrl_mute = 1'b0;
   int ctrl_lat = 5;
   logic [DATA_W-1:0] ctrl_rdata = '0;
   logic [DATA_W-1:0] mem_model [int];
   int pend = 0;
   logic [ADDR_W-1:0] c_addr = '0;
   logic c_we = 1'b0;
   logic [DATA_W-1:0] c_wdata = '0;

   assign mem_done  = ctrl_done | stray_done;
   assign mem_rdata = stray_done ? 32'hBAD0BAD0 : ctrl_rdata;

   typedef struct {
      logic        client;
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;
   exp_t sb[$];

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   psram_req_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
      .rdata0(rdata0), .rdata1(rdata1),
      .mem_start(mem_start), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_abort(mem_abort),
      .mem_done(mem_done), .mem_rdata(mem_rdata),
      .busy(busy), .grant_id(grant_id)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic start_req(input bit c, input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      if (!c) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
      else    begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
   endtask

   task automatic wait_ack(input int limit);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(ack0 || ack1) && n < limit);
      if (!(ack0 || ack1)) begin
         checks++;
         errors++;
         $display("FAIL ack_timeout: no ack within %0d cycles", limit);
      end
   endtask

   // PSRAM controller model: answers ctrl_lat cycles after mem_start
   initial begin
      forever begin
         @(posedge clk or posedge rst);
         #1;
         ctrl_done = 1'b0;
         if (rst) begin
            pend = 0;
         end else begin
            if (pend > 0) begin
               pend--;
               if (pend == 0) begin
                  ctrl_done = 1'b1;
                  if (c_we) mem_model[int'(c_addr)] = c_wdata;
                  else ctrl_rdata = mem_model.exists(int'(c_addr)) ? mem_model[int'(c_addr)] : '0;
               end
            end
            if (mem_start && !ctrl_mute) begin
               pend    = ctrl_lat;
               c_addr  = mem_addr;
               c_we    = mem_we;
               c_wdata = mem_wdata;
            end
         end
      end
   end

   // Monitor: every ack pops one expected response
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (ack0 || ack1) begin
            check("ack_exclusive", ack0 & ack1, 0);
            if (sb.size() == 0) begin
               check("unexpected_ack", {ack1, ack0}, 0);
            end else begin
               e = sb.pop_front();
               check("ack_client", ack1, e.client);
               check("grant_id", grant_id, e.client);
               check("rdata", e.client ? rdata1 : rdata0, e.rdata);
               check("err", e.client ? err1 : err0, e.err);
               if (e.cyc >= 0) check("ack_cycle", cyc, e.cyc);
            end
         end else if (err0 || err1) begin
            check("err_without_ack", {err1, err0}, 0);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int t;
      mem_model[32'h000100] = 32'hDEADBEEF;
      mem_model[32'h000200] = 32'h11110000;
      mem_model[32'h000300] = 32'h22220000;

      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_ack", {ack1, ack0}, 0);
      check("rst_err", {err1, err0}, 0);
      check("rst_start_abort", {mem_start, mem_abort}, 0);
      check("rst_rdata0", rdata0, 0);
      check("rst_rdata1", rdata1, 0);
      check("rst_mem_cmd", {mem_we, mem_addr, mem_wdata}, 0);
      check("rst_grant_id", grant_id, 0);
      rst = 1'b0;

      // Single read by client 0, L=5
      @(posedge clk); #1;
      t = cyc;
      sb.push_back('{client: 1'b0, rdata: 32'hDEADBEEF, err: 1'b0, cyc: t + 7});
      start_req(1'b0, 1'b0, 24'h000100, '0);
      @(negedge clk); @(negedge clk);
      check("t1_start", mem_start, 1);
      check("t1_addr", mem_addr, 24'h000100);
      check("t1_we", mem_we, 0);
      check("t1_busy", busy, 1);
      @(negedge clk);
      check("t1_start_once", mem_start, 0);
      wait_ack(50);
      req0 = 1'b0;

      // Both clients reading continuously from reset: alternating grants
      @(posedge clk); #1;
      rst = 1'b1;
      ctrl_lat = 3;
      start_req(1'b0, 1'b0, 24'h000200, '0);
      start_req(1'b1, 1'b0, 24'h000300, '0);
      sb.push_back('{client: 1'b0, rdata: 32'h11110000, err: 1'b0, cyc: -1});
      sb.push_back('{client: 1'b1, rdata: 32'h22220000, err: 1'b0, cyc: -1});
      sb.push_back('{client: 1'b0, rdata: 32'h11110000, err: 1'b0, cyc: -1});
      sb.push_back('{client: 1'b1, rdata: 32'h22220000, err: 1'b0, cyc: -1});
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) wait_ack(50);
      req0 = 1'b0;
      req1 = 1'b0;

      // Client 1 write: rdata1 keeps its previous value
      @(posedge clk); #1;
      t = cyc;
      sb.push_back('{client: 1'b1, rdata: 32'h22220000, err: 1'b0, cyc: t + 5});
      start_req(1'b1, 1'b1, 24'h00ABCD, 32'h12345678);
      @(negedge clk); @(negedge clk);
      check("t3_start", mem_start, 1);
      check("t3_we", mem_we, 1);
      check("t3_addr", mem_addr, 24'h00ABCD);
      check("t3_wdata", mem_wdata, 32'h12345678);
      check("t3_grant", grant_id, 1);
      wait_ack(50);
      req1 = 1'b0;
      we1  = 1'b0;
      @(posedge clk); #1;
      sb.push_back('{client: 1'b0, rdata: 32'h12345678, err: 1'b0, cyc: -1});
      start_req(1'b0, 1'b0, 24'h00ABCD, '0);
      wait_ack(50);
      req0 = 1'b0;

      // Reset two cycles into WAIT
      @(posedge clk); #1;
      ctrl_lat = 20;
      start_req(1'b1, 1'b0, 24'h000300, '0);
      repeat (4) @(posedge clk);
      #1;
      check("t4_busy_pre", busy, 1);
      #2;
      rst = 1'b1;
      #1;
      check("t4_busy", busy, 0);
      check("t4_ack_start", {ack1, ack0, mem_start, mem_abort}, 0);
      check("t4_mem_cmd", {mem_we, mem_addr, mem_wdata}, 0);
      check("t4_rdata", {rdata1, rdata0}, 0);
      check("t4_grant_id", grant_id, 0);
      req1 = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      ctrl_lat = 3;
      repeat (30) @(negedge clk);
      check("t4_idle_after", busy, 0);
      @(posedge clk); #1;
      sb.push_back('{client: 1'b0, rdata: 32'h22220000, err: 1'b0, cyc: -1});
      sb.push_back('{client: 1'b1, rdata: 32'h11110000, err: 1'b0, cyc: -1});
      start_req(1'b0, 1'b0, 24'h000300, '0);
      start_req(1'b1, 1'b0, 24'h000200, '0);
      wait_ack(50);
      req0 = 1'b0;
      wait_ack(50);
      req1 = 1'b0;

      // Stray mem_done in IDLE and in ISSUE
      @(posedge clk); #1;
      stray_done = 1'b1;
      @(posedge clk); #1;
      stray_done = 1'b0;
      repeat (3) @(negedge clk);
      check("t5_idle_busy", busy, 0);
      @(posedge clk); #1;
      t = cyc;
      ctrl_lat = 4;
      sb.push_back('{client: 1'b0, rdata: 32'hDEADBEEF, err: 1'b0, cyc: t + 6});
      start_req(1'b0, 1'b0, 24'h000100, '0);
      @(posedge clk); #1;
      stray_done = 1'b1;
      @(posedge clk); #1;
      stray_done = 1'b0;
      wait_ack(50);
      req0 = 1'b0;

      // Controller never answers
      @(posedge clk); #1;
      ctrl_mute = 1'b1;
      t = cyc;
`ifdef PSRAM_ARB_TIMEOUT_EN
      sb.push_back('{client: 1'b0, rdata: 32'h0, err: 1'b1, cyc: t + 18});
      start_req(1'b0, 1'b0, 24'h000200, '0);
      repeat (16) @(posedge clk);
      @(negedge clk);
      check("t6_abort_early", mem_abort, 0);
      @(negedge clk);
      check("t6_abort", mem_abort, 1);
      wait_ack(10);
      req0 = 1'b0;
`else
      start_req(1'b0, 1'b0, 24'h000200, '0);
      repeat (40) @(negedge clk);
      check("t6_busy_hang", busy, 1);
      check("t6_err0", err0, 0);
      check("t6_abort", mem_abort, 0);
      req0 = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
`endif
      ctrl_mute = 1'b0;

      repeat (5) @(negedge clk);
      check("sb_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/psram_req_arbiter.md
Name: psram_req_arbiter

Overview:
- Shares the single QSPI PSRAM controller port of the KWS CNN accelerator between two requesters: client 0 is the weight fetch unit and client 1 is the feature/activation buffer.
- Serialises one-word read/write transactions with round-robin fairness.
- Latches each request and drives the controller's start/addr/data command interface.
- Routes the controller's completion and read data back to the granted client.

Parameters:
- ADDR_W, 24, PSRAM word address width.
- DATA_W, 32, transaction data width.
- TIMEOUT_CYCLES, 1024, watchdog limit in WAIT. Used only with PSRAM_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock (wb_clk_i domain)
- rst  in  1  asynchronous, active-high reset
- req0 / req1  in  1  transaction request, one per client
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDR_W  word address
- wdata0 / wdata1  in  DATA_W  write data
- ack0 / ack1  out  1  one-cycle completion pulse
- err0 / err1  out  1  one-cycle timeout error, coincident with ack
- rdata0 / rdata1  out  DATA_W  read data; valid with ack, held until that client's next ack
- mem_start  out  1  one-cycle command strobe to the PSRAM controller
- mem_we  out  1  latched write enable
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched write data
- mem_abort  out  1  one-cycle abort to the controller (timeout only)
- mem_done  in  1  one-cycle completion from the controller
- mem_rdata  in  DATA_W  read data; valid with mem_done
- busy  out  1  high whenever state != IDLE
- grant_id  out  1  index of the current or last granted client

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; last_grant=1, so client 0 wins the first tie.
  - All ack, err, mem_start and mem_abort outputs are 0; busy=0.
  - rdata0, rdata1, mem_addr, mem_wdata and mem_we are 0; grant_id=0.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - Only req1 high: grant client 1.
  - Only req0 high: grant client 0.
  - Both high: grant the client != last_grant.
  - On grant, the granted client's we/addr/wdata are latched into mem_we/mem_addr/mem_wdata, grant_id is updated, and the FSM moves to ISSUE.
  - No request: stay in IDLE.
- ISSUE: mem_start=1 for exactly this cycle; go to WAIT.
- WAIT:
  - mem_done=1: capture mem_rdata into the granted client's rdata register; go to RESP.
  - mem_done is sampled only in WAIT; a done pulse in any other state is ignored.
- RESP:
  - ack of the granted client is 1 for this cycle.
  - last_grant <= grant_id; go to IDLE.
- Latency:
  - The request is sampled in cycle t.
  - mem_start fires at t+1.
  - ack fires 1 cycle after the mem_done cycle.
  - With the controller answering in L cycles after start, ack fires at t+L+2.
  - The minimum gap between back-to-back grants is one IDLE cycle.
- Write transactions: rdata of the client is unchanged; ack is still pulsed.
- Requester contract:
  - Hold req, we, addr and wdata stable until ack.
  - Deassert req in the ack cycle or the next cycle; the arbiter re-samples only in IDLE.
  - If req is dropped mid-transaction, the transaction still completes and ack is still pulsed.
- Fairness: each client gets at most one transaction before the other is served when both are continuously requesting.
- Reset mid-operation:
  - Immediate return to IDLE; the in-flight transaction is discarded and no ack is issued.
  - The PSRAM controller shares rst.
- mem_* command outputs hold their latched values between transactions.

Optional Feature:
- Macro: PSRAM_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES-1 without mem_done: mem_abort=1 for one cycle, the FSM enters RESP, and the granted client gets ack and err together with rdata forced to 0 (reads only).
  - mem_done in the same cycle as the timeout wins: normal completion, no err.
- Undefined: no counter; err0, err1 and mem_abort are tied to 0; WAIT waits indefinitely.

Test Plan:
- Single read, client 0 at addr 0x000100; controller returns 0xDEADBEEF with L=5 -> mem_start at t+1 with mem_addr=0x000100, mem_we=0; ack0 at t+7; rdata0=0xDEADBEEF; ack1 never asserts.
- req0 and req1 both high from reset, both reads, held continuously -> grants alternate 0,1,0,1 (grant_id sequence); four acks in that order; never two consecutive grants to the same client.
- Client 1 write, addr 0x00ABCD, data 0x12345678 -> mem_we=1, mem_wdata=0x12345678 on mem_start; ack1 pulses; rdata1 keeps its previous value.
- rst asserted two cycles into WAIT -> busy=0 and all outputs 0 asynchronously; no ack issued; next request after reset is granted normally with client 0 priority.
- Stray mem_done in IDLE and in ISSUE -> ignored; no ack; FSM still waits for a done in WAIT.
- With PSRAM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, controller never responds to a client 0 read -> mem_abort after 16 WAIT cycles; ack0=err0=1 next cycle; rdata0=0. Without the macro -> busy stays high and err0 stays 0.
